// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding
// and the byte-enable mask used to split misaligned writes into two beats.
package dmem_resp_pkg;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_DONE, WR_B} dmem_resp_state_e;

  localparam int WORD_BYTES = 8;
  localparam int OFS_BITS   = 3;

  // Bits [7:0] enable beat 0; bits [15:8] enable beat 1 (next word).
  function automatic logic [15:0] be_mask(input logic [OFS_BITS-1:0] offset,
                                          input logic [3:0]          nbytes);
    logic [15:0] m;
    m = (16'h1 << nbytes) - 16'h1;
    return m << offset;
  endfunction

endpackage

// File: rtl/bytewise_sram.sv
// Single-port DEPTH_WORDS x 64 SRAM with per-byte write enables and a
// registered read port (one cycle latency).
module bytewise_sram #(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts core dmem requests, splits word-crossing
// accesses into two SRAM beats and signals completion via busy/rdy.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dmem_rd_en_i,
  input  logic                             dmem_wr_en_i,
  input  logic [DATA_WIDTH-1:0]            dmem_addr_i,
  input  logic [$clog2(FETCH_WIDTH/8)-1:0] dmem_wr_size_i,
  input  logic [FETCH_WIDTH-1:0]           dmem_wr_data_i,
  output logic                             dmem_busy_o,
  output logic                             dmem_rdy_o,
  output logic [FETCH_WIDTH-1:0]           dmem_rd_data_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_resp_state_e state;

  logic [AW-1:0]       idx_q;
  logic [OFS_BITS-1:0] ofs_q;
  logic                cross_q;
  logic [7:0]          be_hi_q;
  logic [63:0]         wd_hi_q;
  logic [63:0]         w0_q;

  logic                s_en, s_we;
  logic [AW-1:0]       s_addr;
  logic [7:0]          s_be;
  logic [63:0]         s_wdata, s_rdata;

  logic                acc;
  logic [AW-1:0]       in_idx;
  logic [OFS_BITS-1:0] in_ofs;
  logic [3:0]          wr_nb;
  logic [15:0]         in_mask;
  logic [127:0]        in_wsh;
  logic                wr_cross;
  logic [63:0]         w0, w1;
  logic [127:0]        rd_pair;
  logic                unused_addr;

  assign acc      = (dmem_rd_en_i | dmem_wr_en_i) & ~dmem_busy_o;
  assign in_idx   = dmem_addr_i[OFS_BITS +: AW];
  assign in_ofs   = dmem_addr_i[OFS_BITS-1:0];
  assign wr_nb    = {1'b0, dmem_wr_size_i} + 4'd1;
  assign in_mask  = be_mask(in_ofs, wr_nb);
  assign in_wsh   = {64'b0, dmem_wr_data_i} << {in_ofs, 3'b000};
  assign wr_cross = |in_mask[15:8];
  // Upper address bits are discarded so accesses wrap around the SRAM.
  assign unused_addr = ^dmem_addr_i[DATA_WIDTH-1:OFS_BITS+AW];

  // Word 0 is parked in w0_q while word 1 is read for crossing accesses.
  assign w0      = cross_q ? w0_q : s_rdata;
  assign w1      = cross_q ? s_rdata : 64'b0;
  assign rd_pair = {w1, w0} >> {ofs_q, 3'b000};

  // Beat-0 writes go straight from the request inputs on the accept edge.
  always_comb begin
    s_en    = 1'b0;
    s_we    = 1'b0;
    s_addr  = idx_q;
    s_be    = be_hi_q;
    s_wdata = wd_hi_q;
    case (state)
      IDLE: if (acc && dmem_wr_en_i) begin
        s_en    = 1'b1;
        s_we    = 1'b1;
        s_addr  = in_idx;
        s_be    = in_mask[7:0];
        s_wdata = in_wsh[63:0];
      end
      RD_A: s_en = 1'b1;
      RD_B: begin
        s_en   = 1'b1;
        s_addr = idx_q + 1'b1;
      end
      WR_B: begin
        s_en   = 1'b1;
        s_we   = 1'b1;
        s_addr = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  bytewise_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk  (clk),
    .en   (s_en),
    .we   (s_we),
    .addr (s_addr),
    .be   (s_be),
    .wdata(s_wdata),
    .rdata(s_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      dmem_busy_o    <= 1'b0;
      dmem_rdy_o     <= 1'b0;
      dmem_rd_data_o <= '0;
      idx_q          <= '0;
      ofs_q          <= '0;
      cross_q        <= 1'b0;
      be_hi_q        <= '0;
      wd_hi_q        <= '0;
      w0_q           <= '0;
    end else begin
      dmem_rdy_o <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          idx_q <= in_idx;
          ofs_q <= in_ofs;
          if (dmem_wr_en_i) begin
            be_hi_q <= in_mask[15:8];
            wd_hi_q <= in_wsh[127:64];
            if (wr_cross) begin
              state       <= WR_B;
              dmem_busy_o <= 1'b1;
            end else begin
              dmem_rdy_o  <= 1'b1;
            end
          end else begin
            cross_q     <= (in_ofs != '0);
            state       <= RD_A;
            dmem_busy_o <= 1'b1;
          end
        end
        WR_B: begin
          state       <= IDLE;
          dmem_busy_o <= 1'b0;
          dmem_rdy_o  <= 1'b1;
        end
        RD_A: state <= cross_q ? RD_B : RD_DONE;
        RD_B: begin
          w0_q  <= s_rdata;
          state <= RD_DONE;
        end
        RD_DONE: begin
          dmem_rd_data_o <= rd_pair[63:0];
          dmem_rdy_o     <= 1'b1;
          dmem_busy_o    <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-level memory model feeds a
// queue of expected read data; latency and busy profile checked per request.
module tb_dmem_responder;

  localparam int DEPTH = 4;
  localparam int MEMB  = DEPTH * 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [63:0] wdata;
  logic        busy, rdy;
  logic [63:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_m [MEMB];
  logic [63:0] exp_q [$];

  dmem_responder #(.DATA_WIDTH(64), .FETCH_WIDTH(64), .DEPTH_WORDS(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .dmem_rd_en_i  (rd_en),
    .dmem_wr_en_i  (wr_en),
    .dmem_addr_i   (addr),
    .dmem_wr_size_i(size),
    .dmem_wr_data_i(wdata),
    .dmem_busy_o   (busy),
    .dmem_rdy_o    (rdy),
    .dmem_rd_data_o(rd_data)
  );

  always #5 clk = ~clk;

  // Drives one request for a single edge; updates the model / scoreboard.
  task automatic issue(input logic r, input logic w, input logic [63:0] a,
                       input logic [2:0] sz, input logic [63:0] d);
    logic [63:0] e;
    @(negedge clk);
    rd_en = r; wr_en = w; addr = a; size = sz; wdata = d;
    if (w) begin
      for (int i = 0; i <= int'(sz); i++) mem_m[(int'(a[4:0]) + i) % MEMB] = d[8*i +: 8];
    end else if (r) begin
      for (int i = 0; i < 8; i++) e[8*i +: 8] = mem_m[(int'(a[4:0]) + i) % MEMB];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Returns the cycle (1 = k+1) in which rdy was seen, 0 on timeout.
  task automatic wait_rdy(output int cyc, output logic [7:0] btr);
    cyc = 0; btr = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      btr[n-1] = busy;
      if (rdy) begin
        cyc = n;
        return;
      end
    end
  endtask

  task automatic test_reset;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", rdy); end
    n_tests++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_tests++;
  endtask

  task automatic test_aligned;
    int c; logic [7:0] b; logic [63:0] e;
    issue(0, 1, 64'h10, 3'd7, 64'h1122334455667788);
    wait_rdy(c, b);
    n_tests++;
    if (c != 1 || b[0] !== 1'b0) begin n_fail++; $display("FAIL aligned_wr_timing got cyc %0d busy %b want 1/0", c, b[0]); end
    issue(1, 0, 64'h10, 3'd0, 64'h0);
    wait_rdy(c, b);
    n_tests++;
    if (c != 3 || b[2:0] !== 3'b011) begin n_fail++; $display("FAIL aligned_rd_timing got cyc %0d busy %b want 3/011", c, b[2:0]); end
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL aligned_rd_data got %h want %h", rd_data, e); end
    @(negedge clk);
    n_tests++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL aligned_rdy_width got %b want 0", rdy); end
  endtask

  task automatic test_partial;
    int c; logic [7:0] b; logic [63:0] e;
    issue(0, 1, 64'h18, 3'd7, 64'hFFFFFFFFFFFFFFFF);
    wait_rdy(c, b);
    issue(0, 1, 64'h1A, 3'd1, 64'hABCD);
    wait_rdy(c, b);
    n_tests++;
    if (c != 1) begin n_fail++; $display("FAIL partial_wr_timing got %0d want 1", c); end
    issue(1, 0, 64'h18, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'hFFFFFFFFABCDFFFF) begin n_fail++; $display("FAIL partial_rd_data got %h want %h", rd_data, e); end
  endtask

  task automatic test_cross_read;
    int c; logic [7:0] b; logic [63:0] e;
    issue(0, 1, 64'h20, 3'd7, 64'h0706050403020100);
    wait_rdy(c, b);
    issue(0, 1, 64'h28, 3'd7, 64'h0F0E0D0C0B0A0908);
    wait_rdy(c, b);
    issue(1, 0, 64'h25, 3'd0, 64'h0);
    wait_rdy(c, b);
    n_tests++;
    if (c != 4 || b[3:0] !== 4'b0111) begin n_fail++; $display("FAIL cross_rd_timing got cyc %0d busy %b want 4/0111", c, b[3:0]); end
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'h0C0B0A0908070605) begin n_fail++; $display("FAIL cross_rd_data got %h want %h", rd_data, e); end
  endtask

  task automatic test_cross_write_wrap;
    int c; logic [7:0] b; logic [63:0] e;
    issue(0, 1, 64'h1E, 3'd3, 64'hDDCCBBAA);
    wait_rdy(c, b);
    n_tests++;
    if (c != 2 || b[1:0] !== 2'b01) begin n_fail++; $display("FAIL cross_wr_timing got cyc %0d busy %b want 2/01", c, b[1:0]); end
    issue(1, 0, 64'h18, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'hBBAAFFFFABCDFFFF) begin n_fail++; $display("FAIL wrap_word3 got %h want %h", rd_data, e); end
    issue(1, 0, 64'h00, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'h070605040302DDCC) begin n_fail++; $display("FAIL wrap_word0 got %h want %h", rd_data, e); end
    issue(1, 0, 64'h1E, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (c != 4 || rd_data !== e || rd_data !== 64'h05040302DDCCBBAA) begin n_fail++; $display("FAIL wrap_rd got %h cyc %0d want %h cyc 4", rd_data, c, e); end
  endtask

  task automatic test_contention;
    int c, pulses, at; logic [7:0] b; logic [63:0] e;
    issue(1, 0, 64'h25, 3'd0, 64'h0);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL contend_busy got %b want 1", busy); end
    wr_en = 1'b1; addr = 64'h08; size = 3'd7; wdata = 64'hDEADBEEFDEADBEEF;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    pulses = 0; at = 0;
    for (int n = 2; n <= 9; n++) begin
      @(negedge clk);
      if (rdy) begin pulses++; at = n; end
    end
    n_tests++;
    if (pulses != 1 || at != 4) begin n_fail++; $display("FAIL contend_rdy got %0d pulses at %0d want 1 at 4", pulses, at); end
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e) begin n_fail++; $display("FAIL contend_rd_data got %h want %h", rd_data, e); end
    issue(1, 0, 64'h08, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'h0F0E0D0C0B0A0908) begin n_fail++; $display("FAIL ignored_wr_leak got %h want %h", rd_data, e); end
    issue(1, 1, 64'h08, 3'd7, 64'h0123456789ABCDEF);
    wait_rdy(c, b);
    n_tests++;
    if (c != 1) begin n_fail++; $display("FAIL both_en_timing got %0d want 1", c); end
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rdy || busy) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL both_en_extra got %0d want 0", pulses); end
    issue(1, 0, 64'h08, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e || rd_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL both_en_data got %h want %h", rd_data, e); end
  endtask

  task automatic test_reset_mid_read;
    int c; logic [7:0] b; logic [63:0] e;
    issue(1, 0, 64'h10, 3'd0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || rdy !== 1'b0 || rd_data !== 64'h0) begin
      n_fail++; $display("FAIL mid_reset got busy %b rdy %b data %h want 0/0/0", busy, rdy, rd_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 0, 64'h10, 3'd0, 64'h0);
    wait_rdy(c, b);
    e = exp_q.pop_front();
    n_tests++;
    if (c != 3 || rd_data !== e || rd_data !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL post_reset_rd got %h cyc %0d want %h cyc 3", rd_data, c, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; size = '0; wdata = '0;
    for (int i = 0; i < MEMB; i++) mem_m[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_aligned;
    test_partial;
    test_cross_read;
    test_cross_write_wrap;
    test_contention;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Synthesizable responder for the core's data-memory port: accepts the core's `dmem_*` read/write requests, services them from an internal byte-enabled 64-bit-word SRAM, and returns completion through the `busy`/`rdy` handshake. It sits where the behavioural cache sits today, on the data side only. It is the first step toward an FPGA-able memory system. Misaligned accesses that cross a word boundary are split internally into two SRAM beats.

## Interface
Parameters:
- `DATA_WIDTH`, 64: address width.
- `FETCH_WIDTH`, 64: data word width; fixed at 64 for this revision.
- `DEPTH_WORDS`, 4096: SRAM depth in 64-bit words; power of two.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `dmem_rd_en_i`  in  1  read request.
- `dmem_wr_en_i`  in  1  write request.
- `dmem_addr_i`  in  DATA_WIDTH  byte address.
- `dmem_wr_size_i`  in  $clog2(FETCH_WIDTH/8)  bytes to write minus one (0 = 1 byte, 7 = 8 bytes).
- `dmem_wr_data_i`  in  FETCH_WIDTH  write data; byte 0 goes to `addr`, little-endian.
- `dmem_busy_o`  out  1  request in service; new requests ignored.
- `dmem_rdy_o`  out  1  one-cycle completion pulse.
- `dmem_rd_data_o`  out  FETCH_WIDTH  8 bytes starting at the read address, little-endian.

## Operation
- Acceptance: a request is accepted on an edge where (`rd_en` | `wr_en`) = 1 and `busy_o` = 0. The responder latches addr, size and data on that edge.
- Priority: if `rd_en` and `wr_en` are both high, the write is performed and the read is dropped. Exactly one `rdy` pulse results.
- Requests presented while `busy_o` = 1 are ignored. Nothing is queued. The core re-presents them.
- Address: word index = addr[3 +: log2(DEPTH_WORDS)]; offset = addr[2:0]. Upper bits are discarded, so accesses wrap modulo DEPTH_WORDS*8 bytes.
- Split rule: an access crosses a word boundary when offset + nbytes > 8, with nbytes = 8 for reads and wr_size+1 for writes. In that case the second beat uses word index + 1, which wraps to 0 at the top of memory.
- FSM states: IDLE, RD_A, RD_B, RD_DONE, WR_B.
  - IDLE: on an accepted read, go to RD_A. On an accepted non-crossing write, perform the write on the accept edge and stay in IDLE (rdy pulses next cycle). On an accepted crossing write, perform beat 0 and go to WR_B.
  - WR_B: perform beat 1, then go to IDLE (rdy pulses next cycle).
  - RD_A: capture word 0. Go to RD_B if crossing, else to RD_DONE.
  - RD_B: capture word 1, then go to RD_DONE.
  - RD_DONE: assemble `rd_data` = ({w1,w0} >> 8*offset)[63:0], pulse rdy, then go to IDLE.
- Write byte enables: beat 0 BE = ((1<<nbytes)-1) << offset, low 8 bits. Beat 1 BE = the bits above 8 of the same mask, shifted down by 8. Data is shifted by 8*offset in the same way.
- `rd_data_o` holds its value until the next read completes. Writes do not change it.
- Reset (asynchronous, mid-operation included):
  - FSM returns to IDLE; `busy_o` = 0, `rdy_o` = 0, `rd_data_o` = 0.
  - SRAM contents are not cleared.
  - An in-flight crossing write may have committed beat 0 only; this is acceptable.

## Timing
- Reset values: `busy_o` 0, `rdy_o` 0, `rd_data_o` 0.
- Take the accept edge as k.
  - Aligned/non-crossing write: rdy high in cycle k+1; busy low throughout.
  - Crossing write: busy high in cycle k+1; rdy high in cycle k+2.
  - Non-crossing read: busy high in cycles k+1..k+2; rdy and valid data in cycle k+3.
  - Crossing read: busy high in k+1..k+3; rdy in k+4.
- `busy_o` drops in the same cycle `rdy_o` rises. A new request may therefore be accepted on the edge ending the rdy cycle.
- SRAM read latency is 1 cycle, registered output. A write and a read never target the SRAM in the same cycle.

## Structure
- Package `dmem_resp_pkg`: state enum `dmem_resp_state_e`; constants `WORD_BYTES` = 8 and `OFS_BITS` = 3; function `be_mask(offset, nbytes)` returning 16 bits.
- Sub-module `bytewise_sram`: single-port, DEPTH_WORDS x 64, 8 byte enables, registered read. It is the only storage.
- Top level `dmem_responder` contains the FSM, the split/shift datapath and the output registers.

## Test plan
- Aligned write then read: write addr 0x10, size 7, data 0x1122334455667788. Then read 0x10 -> rdy at k+3, rd_data 0x1122334455667788.
- Partial write: preload 0x18 with all 0xFF. Write addr 0x1A, size 1, data 0xABCD. Read 0x18 -> 0xFFFFFFFFABCDFFFF.
- Crossing read: words 0x20 = 0x0706050403020100, 0x28 = 0x0F0E0D0C0B0A0908. Read 0x25 -> 0x0C0B0A0908070605, rdy at k+4, busy high for 3 cycles.
- Crossing write with wrap: DEPTH_WORDS = 4. Write addr 0x1E, size 3, data 0xDDCCBBAA -> word 3 bytes 6,7 = AA,BB and word 0 bytes 0,1 = CC,DD.
- Contention:
  - Request while busy is ignored: no extra rdy.
  - Simultaneous rd_en and wr_en -> write occurs, exactly one rdy at k+1.
- Reset mid-read: assert rst in cycle k+2 -> busy, rdy and rd_data all 0 immediately. After release, a fresh read completes normally and prior SRAM data survives.
